neq_compare_sequencer: RTL and testbench

//  Compares two wide operands (WORDS*N bits) for inequality by streaming one N-bit word per cycle

---
 rtl/neq_seq_pkg.sv | 10 +
 rtl/neq_compare_sequencer_logical_neq.sv | 30 +++
 rtl/neq_compare_sequencer.sv | 103 ++++++++++
 tb/tb_neq_compare_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neq_seq_pkg.sv
// Shared types for the word-serial inequality sequencer.
package neq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } neq_seq_state_e;

endpackage

// File: rtl/neq_compare_sequencer_logical_neq.sv
// N-bit inequality unit; MODEL selects the coding style of an identical function.
module LogicalNEQ #(
  parameter string       MODEL = "Structural",
  parameter int unsigned N     = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         c
);

  generate
    if (MODEL == "Behavioral") begin : g_beh
      always_comb begin
        c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
          if (a[i] != b[i]) c = 1'b1;
        end
      end
    end else if (MODEL == "DataFlow") begin : g_df
      assign c = |(a ^ b);
    end else begin : g_str
      logic [N-1:0] diff;
      for (genvar i = 0; i < int'(N); i++) begin : g_bit
        xor u_xor (diff[i], a[i], b[i]);
      end
      assign c = |diff;
    end
  endgenerate

endmodule

// File: rtl/neq_compare_sequencer.sv
// Streams captured operands one word per cycle through a shared LogicalNEQ and
// reports overall inequality plus the lowest mismatching word index.
module neq_compare_sequencer
  import neq_seq_pkg::*;
#(
  parameter string       MODEL      = "Structural",
  parameter int unsigned N          = 8,
  parameter int unsigned WORDS      = 4,
  parameter bit          EARLY_EXIT = 1'b1,
  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WORDS*N-1:0] a_vec,
  input  logic [WORDS*N-1:0] b_vec,
  output logic               busy,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               neq,
  output logic [IDX_W-1:0]   first_idx
);

  neq_seq_state_e            state_q, state_d;
  logic [WORDS-1:0][N-1:0]   a_q, b_q;
  logic [N-1:0]              word_a, word_b;
  logic [IDX_W-1:0]          idx_q, first_q;
  logic                      neq_q;
  logic                      word_neq;
  logic                      last_word;
  logic                      stop_scan;
  logic                      accept;

  // Current word of the captured operands; a single-word operand needs no mux.
  generate
    if (WORDS == 1) begin : g_one
      assign word_a = a_q[0];
      assign word_b = b_q[0];
    end else begin : g_many
      assign word_a = a_q[idx_q];
      assign word_b = b_q[idx_q];
    end
  endgenerate

  LogicalNEQ #(.MODEL(MODEL), .N(N)) u_LogicalNEQ (
    .a (word_a),
    .b (word_b),
    .c (word_neq)
  );

  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign stop_scan = last_word || (word_neq && EARLY_EXIT);
  assign accept    = (state_q == IDLE) && start_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = COMPARE;
      COMPARE: if (stop_scan)   state_d = DONE;
      DONE:    if (done_ready)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done_valid  = (state_q == DONE);
  end

  // Operand capture, scan index and sticky first-mismatch result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      neq_q   <= 1'b0;
      first_q <= '0;
    end else if (accept) begin
      a_q     <= a_vec;
      b_q     <= b_vec;
      idx_q   <= '0;
      neq_q   <= 1'b0;
      first_q <= '0;
    end else if (state_q == COMPARE) begin
      if (word_neq && !neq_q) begin
        neq_q   <= 1'b1;
        first_q <= idx_q;
      end
      if (!stop_scan) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign neq       = neq_q;
  assign first_idx = first_q;

endmodule

// File: tb/tb_neq_compare_sequencer.sv
// Lockstep bench for four sequencer variants sharing one stimulus stream.
module tb_neq_compare_sequencer;

  localparam int unsigned NI = 4;

  typedef struct packed {
    logic       neq;
    logic [1:0] first;
    logic [7:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_valid = 1'b0;
  logic        done_ready = 1'b1;
  logic [31:0] a_vec = '0;
  logic [31:0] b_vec = '0;

  logic [NI-1:0]      start_ready_w, busy_w, done_valid_w, neq_w;
  logic [NI-1:0][1:0] first_w;
  logic               first1;

  int unsigned words_p [NI] = '{4, 4, 4, 1};
  bit          ee_p    [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  exp_t sb [NI][$];
  exp_t cur [NI];
  bit   active [NI];
  bit   hold [NI];
  bit   idle_chk [NI];
  int   cnt [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neq_compare_sequencer #(.MODEL("Structural"), .N(8), .WORDS(4), .EARLY_EXIT(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_w[0]),
    .a_vec(a_vec), .b_vec(b_vec), .busy(busy_w[0]), .done_valid(done_valid_w[0]),
    .done_ready(done_ready), .neq(neq_w[0]), .first_idx(first_w[0]));

  neq_compare_sequencer #(.MODEL("Behavioral"), .N(8), .WORDS(4), .EARLY_EXIT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_w[1]),
    .a_vec(a_vec), .b_vec(b_vec), .busy(busy_w[1]), .done_valid(done_valid_w[1]),
    .done_ready(done_ready), .neq(neq_w[1]), .first_idx(first_w[1]));

  neq_compare_sequencer #(.MODEL("DataFlow"), .N(8), .WORDS(4), .EARLY_EXIT(1'b1)) u_dut_d (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_w[2]),
    .a_vec(a_vec), .b_vec(b_vec), .busy(busy_w[2]), .done_valid(done_valid_w[2]),
    .done_ready(done_ready), .neq(neq_w[2]), .first_idx(first_w[2]));

  neq_compare_sequencer #(.MODEL("Structural"), .N(8), .WORDS(1), .EARLY_EXIT(1'b1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_w[3]),
    .a_vec(a_vec[7:0]), .b_vec(b_vec[7:0]), .busy(busy_w[3]), .done_valid(done_valid_w[3]),
    .done_ready(done_ready), .neq(neq_w[3]), .first_idx(first1));

  assign first_w[3] = {1'b0, first1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: scan words LSB first, first mismatch is sticky, early exit shortens latency.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned w, input bit ee);
    exp_t       e;
    logic [7:0] wa, wb;
    bit         stop;
    e.neq   = 1'b0;
    e.first = 2'd0;
    e.lat   = 8'(w + 1);
    stop    = 1'b0;
    for (int k = 0; k < int'(w); k++) begin
      wa = a[k*8 +: 8];
      wb = b[k*8 +: 8];
      if (!stop && wa != wb && !e.neq) begin
        e.neq   = 1'b1;
        e.first = 2'(k);
        if (ee) begin
          e.lat = 8'(k + 2);
          stop  = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Monitor: measures accept-to-done latency and pops the scoreboard on done_valid.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < int'(NI); i++) begin
        active[i]   = 1'b0;
        hold[i]     = 1'b0;
        idle_chk[i] = 1'b0;
        sb[i].delete();
      end
    end else begin
      for (int i = 0; i < int'(NI); i++) begin
        if (idle_chk[i]) begin
          check_eq($sformatf("ready_after_done[%0d]", i), 32'(start_ready_w[i]), 32'd1);
          check_eq($sformatf("valid_after_done[%0d]", i), 32'(done_valid_w[i]), 32'd0);
          idle_chk[i] = 1'b0;
        end
        if (active[i]) begin
          cnt[i]++;
          if (done_valid_w[i]) begin
            if (!hold[i]) begin
              if (sb[i].size() == 0) begin
                check_eq($sformatf("sb_empty[%0d]", i), 32'd1, 32'd0);
                cur[i] = '0;
              end else begin
                cur[i] = sb[i].pop_front();
              end
              check_eq($sformatf("latency[%0d]", i), 32'(cnt[i]), 32'(cur[i].lat));
              hold[i] = 1'b1;
            end
            check_eq($sformatf("neq[%0d]", i), 32'(neq_w[i]), 32'(cur[i].neq));
            check_eq($sformatf("first_idx[%0d]", i), 32'(first_w[i]), 32'(cur[i].first));
            check_eq($sformatf("ready_in_done[%0d]", i), 32'(start_ready_w[i]), 32'd0);
            if (done_ready) begin
              active[i]   = 1'b0;
              hold[i]     = 1'b0;
              idle_chk[i] = 1'b1;
            end
          end else if (cnt[i] > 40) begin
            check_eq($sformatf("done_timeout[%0d]", i), 32'd0, 32'd1);
            active[i] = 1'b0;
          end else begin
            check_eq($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'd1);
          end
        end else begin
          check_eq($sformatf("idle_valid[%0d]", i), 32'(done_valid_w[i]), 32'd0);
        end
        if (start_valid && start_ready_w[i] && !active[i]) begin
          active[i] = 1'b1;
          cnt[i]    = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (start_ready_w !== '1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check_eq("idle_timeout", 32'(start_ready_w), 32'hF);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    for (int i = 0; i < int'(NI); i++) sb[i].push_back(model(a, b, words_p[i], ee_p[i]));
    a_vec       = a;
    b_vec       = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_vec       = $urandom;
    b_vec       = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < int'(NI); i++) begin
      check_eq($sformatf("%s_ready[%0d]", tag, i), 32'(start_ready_w[i]), 32'd1);
      check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("%s_valid[%0d]", tag, i), 32'(done_valid_w[i]), 32'd0);
      check_eq($sformatf("%s_neq[%0d]", tag, i), 32'(neq_w[i]), 32'd0);
      check_eq($sformatf("%s_first[%0d]", tag, i), 32'(first_w[i]), 32'd0);
    end
  endtask

  logic [31:0] va [6] = '{32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h0000005A,
                          32'h12345678, 32'hCAFEF00D};
  logic [31:0] vb [6] = '{32'hDEADBEEF, 32'h00FF0000, 32'hFF0000FF, 32'h0000005B,
                          32'h92345678, 32'hCAFEF00C};

  initial begin
    logic [31:0] ra, rb;
    int t;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 6; v++) do_req(va[v], vb[v]);

    // Random operands, half equal and half differing in one random word.
    for (int v = 0; v < 8; v++) begin
      ra = $urandom;
      rb = ra;
      if (v[0]) rb[8*$urandom_range(0, 3) +: 8] ^= 8'(1 + $urandom_range(0, 254));
      do_req(ra, rb);
    end

    // Consumer stalls in DONE; a competing request must be ignored.
    wait_idle();
    done_ready = 1'b0;
    do_req(32'h11223344, 32'h11223244);
    t = 0;
    while (done_valid_w !== '1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("all_done_for_stall", 32'(done_valid_w), 32'hF);
    for (int c = 0; c < 10; c++) begin
      start_valid = 1'b1;
      a_vec       = $urandom;
      b_vec       = ~a_vec;
      @(posedge clk);
      #1;
      check_eq("stall_ready_low", 32'(start_ready_w), 32'h0);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;

    // Reset while the EARLY_EXIT=0 unit is mid-scan at idx 1 with a mismatch recorded.
    wait_idle();
    a_vec       = 32'h00000000;
    b_vec       = 32'h000000FF;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(busy_w[1]), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midscan_rst");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    do_req(32'hA5A5A5A5, 32'hA5A5A5A5);
    do_req(32'h0000005A, 32'h0000005B);
    wait_idle();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NI); i++)
      check_eq($sformatf("sb_leftover[%0d]", i), 32'(sb[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
